// File: rtl/display_pkg.sv
// Shared types and segment constants for the BCD display stage.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH
  } estado_t;

  localparam int MAX_N = 6;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low, bit6 = g down to bit0 = a
  localparam logic [6:0] SEG_DIG [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100,
    7'b0110000, 7'b0011001, 7'b0010010,
    7'b0000010, 7'b1111000, 7'b0000000,
    7'b0010000
  };

endpackage

// File: rtl/display_bcd_secuencial_if.sv
// Count-in / segments-out bundle between the counter and the display stage.
interface display_bcd_secuencial_if #(
  parameter int N = 6
);

  logic [N-1:0] registroContador;
  logic [6:0]   sSegment1;
  logic [6:0]   sSegment2;
  logic         busy;
  logic         done;

  modport master (
    output registroContador,
    input  sSegment1,
    input  sSegment2,
    input  busy,
    input  done
  );

  modport slave (
    input  registroContador,
    output sSegment1,
    output sSegment2,
    output busy,
    output done
  );

endinterface

// File: rtl/bcd_a_7seg.sv
// Combinational BCD nibble to active-low seven-segment decoder.
module bcd_a_7seg
  import display_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (nib)
      4'd0: seg = SEG_DIG[0];
      4'd1: seg = SEG_DIG[1];
      4'd2: seg = SEG_DIG[2];
      4'd3: seg = SEG_DIG[3];
      4'd4: seg = SEG_DIG[4];
      4'd5: seg = SEG_DIG[5];
      4'd6: seg = SEG_DIG[6];
      4'd7: seg = SEG_DIG[7];
      4'd8: seg = SEG_DIG[8];
      4'd9: seg = SEG_DIG[9];
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_bcd_secuencial.sv
// Binary count to two seven-segment digits via a sequential
// shift-add-3 engine; segments only change on a finished conversion.
module display_bcd_secuencial
  import display_pkg::*;
#(
  parameter int N             = 6,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset,
  display_bcd_secuencial_if.slave  bus
);

  localparam int IW = $clog2(N + 1);
  localparam logic [IW-1:0] ITER_LAST = IW'(N - 1);
  localparam logic [6:0] SEG2_RST =
    BLANK_LEADING ? SEG_BLANK : SEG_DIG[0];

  if (N > MAX_N || N < 1) begin : g_bad_n
    $error("display_bcd_secuencial: N out of range");
  end

  estado_t       state_q, state_d;
  logic [N-1:0]  shadow_q, shadow_d;
  logic [N-1:0]  ultimo_q, ultimo_d;
  logic [7:0]    bcd_q, bcd_d;
  logic [IW-1:0] iter_q, iter_d;
  logic          pend_q, pend_d;
  logic [6:0]    seg1_q, seg1_d;
  logic [6:0]    seg2_q, seg2_d;
  logic          done_q, done_d;

  logic [7:0]    bcd_adj;
  logic [6:0]    dec_u;
  logic [6:0]    dec_t;

  bcd_a_7seg u_dec_u (
    .nib (bcd_q[3:0]),
    .seg (dec_u)
  );

  bcd_a_7seg u_dec_t (
    .nib (bcd_q[7:4]),
    .seg (dec_t)
  );

  always_comb begin
    bcd_adj[3:0] = (bcd_q[3:0] >= 4'd5) ?
      bcd_q[3:0] + 4'd3 : bcd_q[3:0];
    bcd_adj[7:4] = (bcd_q[7:4] >= 4'd5) ?
      bcd_q[7:4] + 4'd3 : bcd_q[7:4];
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    ultimo_d = ultimo_q;
    bcd_d    = bcd_q;
    iter_d   = iter_q;
    pend_d   = pend_q;
    seg1_d   = seg1_q;
    seg2_d   = seg2_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pend_q ||
            bus.registroContador != ultimo_q) begin
          shadow_d = bus.registroContador;
          ultimo_d = bus.registroContador;
          bcd_d    = '0;
          iter_d   = '0;
          pend_d   = 1'b0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, shadow_d} = {bcd_adj, shadow_q} << 1;
        iter_d = iter_q + 1'b1;
        if (iter_q == ITER_LAST) state_d = LATCH;
      end
      LATCH: begin
        seg1_d  = dec_u;
        seg2_d  = (BLANK_LEADING && bcd_q[7:4] == 4'd0) ?
          SEG_BLANK : dec_t;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      ultimo_q <= '0;
      bcd_q    <= '0;
      iter_q   <= '0;
      pend_q   <= 1'b1;
      seg1_q   <= SEG_DIG[0];
      seg2_q   <= SEG2_RST;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      ultimo_q <= ultimo_d;
      bcd_q    <= bcd_d;
      iter_q   <= iter_d;
      pend_q   <= pend_d;
      seg1_q   <= seg1_d;
      seg2_q   <= seg2_d;
      done_q   <= done_d;
    end
  end

  assign bus.sSegment1 = seg1_q;
  assign bus.sSegment2 = seg2_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_display_bcd_secuencial.sv
// Directed bench: three display instances (N=6 blanked, N=6 unblanked, N=2).
module tb_display_bcd_secuencial;

  logic clk;
  logic rst_a, rst_b, rst_c;

  int checks = 0;
  int failures = 0;

  display_bcd_secuencial_if #(.N(6)) ia ();
  display_bcd_secuencial_if #(.N(6)) ib ();
  display_bcd_secuencial_if #(.N(2)) ic ();

  display_bcd_secuencial #(.N(6), .BLANK_LEADING(1'b1)) dut_a (
    .clock (clk),
    .reset (rst_a),
    .bus   (ia)
  );

  display_bcd_secuencial #(.N(6), .BLANK_LEADING(1'b0)) dut_b (
    .clock (clk),
    .reset (rst_b),
    .bus   (ib)
  );

  display_bcd_secuencial #(.N(2), .BLANK_LEADING(1'b1)) dut_c (
    .clock (clk),
    .reset (rst_c),
    .bus   (ic)
  );

  logic [2:0] dn;
  assign dn = {ic.done, ib.done, ia.done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] val;
    logic [6:0] s2;
    logic [6:0] s1;
  } vec_t;

  vec_t tbl [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Ticks until done on instance s; n = edges taken (30 = timed out)
  task automatic wait_done(input int s, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!dn[s] && n < 30);
  endtask

  int n;
  int cnt;
  logic [6:0] c_exp [4];

  initial begin
    tbl[0] = '{6'd63, 7'b0000010, 7'b0110000};
    tbl[1] = '{6'd0,  7'b1111111, 7'b1000000};
    tbl[2] = '{6'd9,  7'b1111111, 7'b0010000};
    tbl[3] = '{6'd10, 7'b1111001, 7'b1000000};
    tbl[4] = '{6'd19, 7'b1111001, 7'b0010000};
    tbl[5] = '{6'd57, 7'b0010010, 7'b1111000};
    tbl[6] = '{6'd38, 7'b0110000, 7'b0000000};
    tbl[7] = '{6'd42, 7'b0011001, 7'b0100100};
    c_exp[0] = 7'b1000000;
    c_exp[1] = 7'b1111001;
    c_exp[2] = 7'b0100100;
    c_exp[3] = 7'b0110000;

    rst_a = 1'b1;
    rst_b = 1'b1;
    rst_c = 1'b1;
    ia.registroContador = '0;
    ib.registroContador = '0;
    ic.registroContador = '0;
    tick();

    check("a_rst_seg1", ia.sSegment1, 7'b1000000);
    check("a_rst_seg2", ia.sSegment2, 7'b1111111);
    check("a_rst_busy", ia.busy, 1'b0);
    check("a_rst_done", ia.done, 1'b0);
    check("b_rst_seg2", ib.sSegment2, 7'b1000000);

    // Forced conversion after reset with value 0
    rst_a = 1'b0;
    tick();
    check("a_first_busy", ia.busy, 1'b1);
    wait_done(0, n);
    check("a_first_lat", n, 7);
    check("a_first_seg1", ia.sSegment1, 7'b1000000);
    check("a_first_seg2", ia.sSegment2, 7'b1111111);
    check("a_first_busy_end", ia.busy, 1'b0);
    tick();
    check("a_first_done_w", ia.done, 1'b0);

    for (int i = 0; i < 8; i++) begin
      ia.registroContador = tbl[i].val;
      tick();
      check($sformatf("v%0d_busy", tbl[i].val), ia.busy, 1'b1);
      wait_done(0, n);
      check($sformatf("v%0d_lat", tbl[i].val), n, 7);
      check($sformatf("v%0d_seg2", tbl[i].val),
            ia.sSegment2, tbl[i].s2);
      check($sformatf("v%0d_seg1", tbl[i].val),
            ia.sSegment1, tbl[i].s1);
      check($sformatf("v%0d_busy_end", tbl[i].val),
            ia.busy, 1'b0);
      tick();
      check($sformatf("v%0d_done_w", tbl[i].val),
            ia.done, 1'b0);
    end

    // Stable input: no more conversions
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ia.done || ia.busy) cnt++;
    end
    check("hold_quiet", cnt, 0);

    // Change during conversion is picked up afterwards
    ia.registroContador = 6'd10;
    tick();
    check("mid_busy", ia.busy, 1'b1);
    tick();
    tick();
    ia.registroContador = 6'd11;
    wait_done(0, n);
    check("mid_lat1", n, 5);
    check("mid_seg2_10", ia.sSegment2, 7'b1111001);
    check("mid_seg1_10", ia.sSegment1, 7'b1000000);
    tick();
    check("mid_recapture", ia.busy, 1'b1);
    wait_done(0, n);
    check("mid_lat2", n, 7);
    check("mid_seg2_11", ia.sSegment2, 7'b1111001);
    check("mid_seg1_11", ia.sSegment1, 7'b1111001);

    // Reset during SHIFT aborts and forces a re-conversion
    tick();
    ia.registroContador = 6'd37;
    tick();
    tick();
    tick();
    check("rmid_busy", ia.busy, 1'b1);
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    check("rmid_seg1", ia.sSegment1, 7'b1000000);
    check("rmid_seg2", ia.sSegment2, 7'b1111111);
    check("rmid_busy0", ia.busy, 1'b0);
    check("rmid_done0", ia.done, 1'b0);
    tick();
    check("rmid_recap", ia.busy, 1'b1);
    wait_done(0, n);
    check("rmid_lat", n, 7);
    check("rmid_seg2", ia.sSegment2, 7'b0110000);
    check("rmid_seg1", ia.sSegment1, 7'b1111000);

    // No leading blank
    rst_b = 1'b0;
    tick();
    check("b_first_busy", ib.busy, 1'b1);
    wait_done(1, n);
    check("b_first_lat", n, 7);
    check("b_zero_seg2", ib.sSegment2, 7'b1000000);
    check("b_zero_seg1", ib.sSegment1, 7'b1000000);
    tick();
    ib.registroContador = 6'd5;
    tick();
    wait_done(1, n);
    check("b5_lat", n, 7);
    check("b5_seg2", ib.sSegment2, 7'b1000000);
    check("b5_seg1", ib.sSegment1, 7'b0010010);

    // N=2 driven by a slow counter
    rst_c = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ic.registroContador = 2'(k);
      cnt = 0;
      for (int j = 0; j < 10; j++) begin
        tick();
        if (ic.done) cnt++;
      end
      check($sformatf("c%0d_dones", k), cnt, 1);
      check($sformatf("c%0d_seg1", k), ic.sSegment1, c_exp[k]);
      check($sformatf("c%0d_seg2", k), ic.sSegment2, 7'b1111111);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
